// File: rtl/nos_mode_sequencer_pkg.sv
// Stream-format types and format-to-clock mapping helpers for the NOS mode sequencer.
package common;

    typedef enum logic {REF_x44 = 1'b0, REF_x48 = 1'b1} Reference;
    typedef enum logic [1:0] {x1 = 2'd0, x2 = 2'd1, x4 = 2'd2, x8 = 2'd3} BITRATE;
    typedef enum logic [1:0] {b16 = 2'd0, b24 = 2'd1, b32 = 2'd2} BITNUM;
    typedef enum logic [1:0] {MCLK_1024fs = 2'd0, MCLK_512fs = 2'd1, MCLK_256fs = 2'd2} MCLK;
    typedef enum logic {NOS16 = 1'b0, NOS24 = 1'b1} NOS_BITNUM;

    typedef enum logic [2:0] {MUTED, MUTING, SWITCH, SETTLE, RUN, ERR} SEQ_STATE;

    // 'ref' is a reserved word, so the reference family field is called fam.
    typedef struct packed {
        Reference fam;
        BITRATE   rate;
        BITNUM    bits;
    } STREAM_FMT;

    localparam STREAM_FMT RESET_FMT = '{fam: REF_x48, rate: x1, bits: b24};

    function automatic MCLK rate_to_mclk(input BITRATE rate);
        case (rate)
            x2:      return MCLK_512fs;
            x4:      return MCLK_256fs;
            default: return MCLK_1024fs;  // x8 never reaches SWITCH
        endcase
    endfunction

    // The NOS interface tops out at 24 bits; 32-bit words are truncated.
    function automatic NOS_BITNUM bits_to_nos(input BITNUM bits);
        if (bits == b16) begin
            return NOS16;
        end
        return NOS24;
    endfunction

endpackage

// File: rtl/nos_mode_sequencer_seq_timer.sv
// Loadable down-counter with terminal-count flag, shared by the MUTING and SETTLE phases.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_eff;

    // The load value is visible in the same cycle it is presented, so a
    // phase of N cycles is loaded with N-1 and N=1 terminates immediately.
    assign count_eff = load ? load_value : count_reg;
    assign tc        = (count_eff == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (tc) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_eff - W'(1);
        end
    end

endmodule

// File: rtl/nos_mode_sequencer.sv
// Sequences mute / clock switch / DAC reset / unmute on every stream-format change.
module nos_mode_sequencer
    import common::*;
#(
    parameter int MUTE_CYCLES   = 1024,
    parameter int SETTLE_CYCLES = 4096
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      lock,
    input  logic      fmt_valid,
    input  Reference  fmt_ref,
    input  BITRATE    fmt_rate,
    input  BITNUM     fmt_bits,
    output logic      mute,
    output logic      dac_rst,
    output Reference  ref_sel,
    output MCLK       mclk_sel,
    output NOS_BITNUM nos_bits,
    output logic      fmt_err,
    output logic      running
);

    localparam int MAX_CYCLES = (MUTE_CYCLES > SETTLE_CYCLES) ? MUTE_CYCLES : SETTLE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    SEQ_STATE  state_reg;
    STREAM_FMT pend_reg;
    STREAM_FMT applied_reg;
    STREAM_FMT fmt_in;
    logic      pend_v_reg;
    logic      tmr_load_reg;
    logic      tmr_tc;
    logic [CW-1:0] tmr_value;
    logic      fmt_new;

    logic      mute_reg;
    logic      dac_rst_reg;
    Reference  ref_sel_reg;
    MCLK       mclk_sel_reg;
    NOS_BITNUM nos_bits_reg;
    logic      fmt_err_reg;
    logic      running_reg;

    assign fmt_in    = '{fam: fmt_ref, rate: fmt_rate, bits: fmt_bits};
    assign fmt_new   = fmt_valid && (fmt_in != applied_reg);
    assign tmr_value = (state_reg == SETTLE) ? CW'(SETTLE_CYCLES - 1) : CW'(MUTE_CYCLES - 1);

    seq_timer #(
        .W(CW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load       (tmr_load_reg),
        .load_value (tmr_value),
        .tc         (tmr_tc)
    );

    // Losing lock discards any reported format, even one arriving this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_reg <= 1'b0;
            pend_reg   <= RESET_FMT;
        end else if (!lock) begin
            pend_v_reg <= 1'b0;
        end else if (fmt_valid) begin
            pend_v_reg <= 1'b1;
            pend_reg   <= fmt_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= MUTED;
            applied_reg  <= RESET_FMT;
            tmr_load_reg <= 1'b0;
            mute_reg     <= 1'b1;
            dac_rst_reg  <= 1'b1;
            ref_sel_reg  <= REF_x48;
            mclk_sel_reg <= MCLK_1024fs;
            nos_bits_reg <= NOS24;
            fmt_err_reg  <= 1'b0;
            running_reg  <= 1'b0;
        end else begin
            tmr_load_reg <= 1'b0;
            if (!lock && state_reg != MUTED && state_reg != MUTING) begin
                // dac_rst keeps its value so the output can decay before reset.
                state_reg    <= MUTING;
                tmr_load_reg <= 1'b1;
                mute_reg     <= 1'b1;
                fmt_err_reg  <= 1'b0;
                running_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    MUTED, MUTING: begin
                        if (state_reg == MUTED || tmr_tc) begin
                            if (lock && pend_v_reg) begin
                                if (pend_reg.rate == x8) begin
                                    state_reg   <= ERR;
                                    dac_rst_reg <= 1'b1;
                                    fmt_err_reg <= 1'b1;
                                end else begin
                                    state_reg <= SWITCH;
                                end
                            end else begin
                                state_reg   <= MUTED;
                                dac_rst_reg <= 1'b1;
                            end
                        end
                    end
                    SWITCH: begin
                        state_reg    <= SETTLE;
                        tmr_load_reg <= 1'b1;
                        applied_reg  <= pend_reg;
                        ref_sel_reg  <= pend_reg.fam;
                        mclk_sel_reg <= rate_to_mclk(pend_reg.rate);
                        nos_bits_reg <= bits_to_nos(pend_reg.bits);
                        dac_rst_reg  <= 1'b1;
                    end
                    SETTLE: begin
                        if (fmt_valid && fmt_rate == x8) begin
                            state_reg   <= ERR;
                            fmt_err_reg <= 1'b1;
                        end else if (fmt_new) begin
                            state_reg <= SWITCH;
                        end else if (tmr_tc) begin
                            state_reg   <= RUN;
                            mute_reg    <= 1'b0;
                            dac_rst_reg <= 1'b0;
                            running_reg <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (fmt_new) begin
                            state_reg    <= MUTING;
                            tmr_load_reg <= 1'b1;
                            mute_reg     <= 1'b1;
                            running_reg  <= 1'b0;
                        end
                    end
                    ERR: begin
                        if (fmt_valid && fmt_rate != x8) begin
                            state_reg   <= SWITCH;
                            fmt_err_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg   <= MUTED;
                        mute_reg    <= 1'b1;
                        dac_rst_reg <= 1'b1;
                        running_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign mute     = mute_reg;
    assign dac_rst  = dac_rst_reg;
    assign ref_sel  = ref_sel_reg;
    assign mclk_sel = mclk_sel_reg;
    assign nos_bits = nos_bits_reg;
    assign fmt_err  = fmt_err_reg;
    assign running  = running_reg;

endmodule

// File: tb/tb_nos_mode_sequencer.sv
// Directed bench for nos_mode_sequencer with a cycle-by-cycle expected-output scoreboard.
module tb_nos_mode_sequencer;
    import common::*;

    localparam int MC = 5;
    localparam int SC = 7;

    logic      clk = 1'b0;
    logic      rst;
    logic      lock;
    logic      fmt_valid;
    Reference  fmt_ref;
    BITRATE    fmt_rate;
    BITNUM     fmt_bits;
    logic      mute;
    logic      dac_rst;
    Reference  ref_sel;
    MCLK       mclk_sel;
    NOS_BITNUM nos_bits;
    logic      fmt_err;
    logic      running;

    typedef struct packed {
        logic      mute;
        logic      dac_rst;
        Reference  ref_sel;
        MCLK       mclk_sel;
        NOS_BITNUM nos_bits;
        logic      fmt_err;
        logic      running;
    } outs_t;

    outs_t exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    nos_mode_sequencer #(
        .MUTE_CYCLES   (MC),
        .SETTLE_CYCLES (SC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .lock      (lock),
        .fmt_valid (fmt_valid),
        .fmt_ref   (fmt_ref),
        .fmt_rate  (fmt_rate),
        .fmt_bits  (fmt_bits),
        .mute      (mute),
        .dac_rst   (dac_rst),
        .ref_sel   (ref_sel),
        .mclk_sel  (mclk_sel),
        .nos_bits  (nos_bits),
        .fmt_err   (fmt_err),
        .running   (running)
    );

    function automatic outs_t mk(input logic m, input logic d, input Reference r,
                                 input MCLK c, input NOS_BITNUM n, input logic e, input logic run);
        outs_t o;
        o.mute     = m;
        o.dac_rst  = d;
        o.ref_sel  = r;
        o.mclk_sel = c;
        o.nos_bits = n;
        o.fmt_err  = e;
        o.running  = run;
        return o;
    endfunction

    task automatic compare(input string tag);
        outs_t e;
        outs_t obs;
        e   = exp_q.pop_front();
        obs = mk(mute, dac_rst, ref_sel, mclk_sel, nos_bits, fmt_err, running);
        checks++;
        assert (obs === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h (mute,dac_rst,ref,mclk,nos,err,run)", tag, obs, e);
        end
        $display("t=%0t %s mute=%0d dac_rst=%0d ref=%0d mclk=%0d nos=%0d err=%0d run=%0d",
                 $time, tag, mute, dac_rst, ref_sel, mclk_sel, nos_bits, fmt_err, running);
    endtask

    task automatic tick(input string tag, input outs_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        fmt_valid = 1'b0;
        compare(tag);
    endtask

    task automatic ticks(input int n, input string tag, input outs_t e);
        for (int i = 0; i < n; i++) begin
            tick(tag, e);
        end
    endtask

    task automatic send(input Reference r, input BITRATE b, input BITNUM n);
        fmt_ref   = r;
        fmt_rate  = b;
        fmt_bits  = n;
        fmt_valid = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "watchdog");
    end

    initial begin
        outs_t rst_o, a_set, a_run, a_mute, c_set, c_run, c_mute, c_err;
        outs_t d_set, d_run, d_mute, f_set;
        rst_o  = mk(1, 1, REF_x48, MCLK_1024fs, NOS24, 0, 0);
        a_set  = mk(1, 1, REF_x44, MCLK_512fs,  NOS16, 0, 0);
        a_run  = mk(0, 0, REF_x44, MCLK_512fs,  NOS16, 0, 1);
        a_mute = mk(1, 0, REF_x44, MCLK_512fs,  NOS16, 0, 0);
        c_set  = mk(1, 1, REF_x48, MCLK_1024fs, NOS16, 0, 0);
        c_run  = mk(0, 0, REF_x48, MCLK_1024fs, NOS16, 0, 1);
        c_mute = mk(1, 0, REF_x48, MCLK_1024fs, NOS16, 0, 0);
        c_err  = mk(1, 1, REF_x48, MCLK_1024fs, NOS16, 1, 0);
        d_set  = mk(1, 1, REF_x48, MCLK_256fs,  NOS24, 0, 0);
        d_run  = mk(0, 0, REF_x48, MCLK_256fs,  NOS24, 0, 1);
        d_mute = mk(1, 0, REF_x48, MCLK_256fs,  NOS24, 0, 0);
        f_set  = mk(1, 1, REF_x44, MCLK_256fs,  NOS24, 0, 0);

        rst       = 1'b1;
        lock      = 1'b0;
        fmt_valid = 1'b0;
        fmt_ref   = REF_x48;
        fmt_rate  = x1;
        fmt_bits  = b24;
        #2;
        exp_q.push_back(rst_o);
        compare("reset");
        rst = 1'b0;

        // First lock: pending load, SWITCH, SETTLE, then RUN
        lock = 1'b1;
        send(REF_x44, x2, b16);
        tick("muted_pend", rst_o);
        tick("switch1", rst_o);
        ticks(SC, "settle1", a_set);
        tick("run1", a_run);

        // Identical format re-reported in RUN is ignored
        send(REF_x44, x2, b16);
        ticks(3, "same_fmt", a_run);

        // New format; a second report mid-MUTING replaces pending without restarting the count
        send(REF_x48, x1, b32);
        for (int i = 0; i <= MC; i++) begin
            if (i == 2) begin
                send(REF_x48, x1, b16);
            end
            tick("muting2", a_mute);
        end
        ticks(SC, "settle2", c_set);
        tick("run2", c_run);

        // Unsupported x8, then recovery to a supported format
        send(REF_x48, x8, b24);
        ticks(MC, "muting_x8", c_mute);
        ticks(3, "err", c_err);
        send(REF_x48, x4, b24);
        tick("err_switch", c_set);
        ticks(SC, "settle3", d_set);
        tick("run3", d_run);

        // Lock drop in RUN: decay with DAC running, then MUTED
        lock = 1'b0;
        ticks(MC, "unlock_run", d_mute);
        ticks(2, "muted", d_set);
        send(REF_x44, x2, b16);
        tick("fmt_no_lock", d_set);
        lock = 1'b1;
        ticks(3, "relock_idle", d_set);

        // Lock drop in SETTLE must never reach RUN
        send(REF_x44, x2, b16);
        ticks(2, "pend_switch4", d_set);
        ticks(2, "settle4", a_set);
        lock = 1'b0;
        ticks(MC + SC + 2, "unlock_settle", a_set);
        lock = 1'b1;
        ticks(3, "relock_idle2", a_set);

        // Reset mid-SETTLE
        send(REF_x44, x4, b32);
        ticks(2, "pend_switch5", a_set);
        ticks(2, "settle5", f_set);
        rst = 1'b1;
        #1;
        exp_q.push_back(rst_o);
        compare("async_rst");
        tick("rst_held", rst_o);
        rst = 1'b0;
        ticks(SC + 4, "after_rst", rst_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
